// File: rtl/hash160_digest_serializer_if.sv
// Handshake bundle between the Hash160 core, the digest serializer and a byte-wide sink.
// master = upstream core plus downstream sink, slave = serializer.
interface hash160_digest_serializer_if #(
  parameter int DIGEST_BYTES = 20
);
  logic                      i_valid;
  logic [8*DIGEST_BYTES-1:0] i_digest;
  logic [7:0]                o_data;
  logic                      o_data_valid;
  logic                      i_data_ready;
  logic                      o_busy;
  logic                      o_done;

  modport master (
    output i_valid, i_digest, i_data_ready,
    input  o_data, o_data_valid, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_digest, i_data_ready,
    output o_data, o_data_valid, o_busy, o_done
  );
endinterface

// File: rtl/hash160_digest_serializer.sv
// Captures a parallel Hash160 digest on each i_valid rising edge and streams it MSB-first
// over valid/ready. Define HASH160_SER_HEX_ASCII_EN to emit lowercase ASCII hex instead.
module hash160_digest_serializer #(
  parameter int DIGEST_BYTES = 20,
  parameter int CNT_W        = 6
) (
  input  logic clk,
  input  logic rst_n,
  hash160_digest_serializer_if.slave bus
);

`ifdef HASH160_SER_HEX_ASCII_EN
  localparam int UNIT_W = 4;
  localparam int BEATS  = 2 * DIGEST_BYTES;
`else
  localparam int UNIT_W = 8;
  localparam int BEATS  = DIGEST_BYTES;
`endif
  localparam int              SR_W      = 8 * DIGEST_BYTES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state_reg;
  logic [SR_W-1:0]  shift_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             valid_d_reg;
  logic [7:0]       data_reg;
  logic             data_valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             start;
  logic             transfer;
  logic [SR_W-1:0]  shift_next;

  assign start      = bus.i_valid & ~valid_d_reg;
  assign transfer   = data_valid_reg & bus.i_data_ready;
  assign shift_next = shift_reg << UNIT_W;

  // Maps one shift unit (byte or nibble) to the byte placed on the wire.
  function automatic logic [7:0] encode(input logic [UNIT_W-1:0] unit);
`ifdef HASH160_SER_HEX_ASCII_EN
    if (unit < 4'd10) return 8'h30 + {4'h0, unit};
    else              return 8'h57 + {4'h0, unit};
`else
    return unit;
`endif
  endfunction

  // o_data is registered from the next shift value so it never depends on i_data_ready
  // combinationally and holds still while a beat is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      valid_d_reg    <= 1'b0;
      data_reg       <= 8'h00;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      valid_d_reg <= bus.i_valid;
      done_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg      <= bus.i_digest;
            cnt_reg        <= '0;
            data_reg       <= encode(bus.i_digest[SR_W-1 -: UNIT_W]);
            data_valid_reg <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= SEND;
          end
        end
        SEND: begin
          if (transfer) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            data_reg  <= encode(shift_next[SR_W-1 -: UNIT_W]);
            if (cnt_reg == LAST_BEAT) begin
              data_valid_reg <= 1'b0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
              state_reg      <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg      <= IDLE;
          data_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data       = data_reg;
  assign bus.o_data_valid = data_valid_reg;
  assign bus.o_busy       = busy_reg;
  assign bus.o_done       = done_reg;

endmodule

// File: tb/tb_hash160_digest_serializer.sv
// Self-checking bench for hash160_digest_serializer: vector table plus hand sequences for
// mid-frame edges and asynchronous reset; expected beats flow through a scoreboard queue.
module tb_hash160_digest_serializer;

  localparam int DB = 20;
`ifdef HASH160_SER_HEX_ASCII_EN
  localparam int BEATS = 2 * DB;
`else
  localparam int BEATS = DB;
`endif

  logic clk;
  logic rst_n;

  hash160_digest_serializer_if #(.DIGEST_BYTES(DB)) bus ();

  hash160_digest_serializer #(.DIGEST_BYTES(DB), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int beats_seen   = 0;
  int done_cnt     = 0;
  int ready_mode   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [159:0] digest;
    int           mode;
    int           hold;
    int           gap;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [7:0] hexchar(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h61 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_expected(input logic [159:0] d);
    logic [7:0] b;
    for (int i = 0; i < DB; i++) begin
      b = d[159 - 8*i -: 8];
`ifdef HASH160_SER_HEX_ASCII_EN
      exp_q.push_back(hexchar(b[7:4]));
      exp_q.push_back(hexchar(b[3:0]));
`else
      exp_q.push_back(b);
`endif
    end
  endtask

  // Sink ready pattern: 0 = always ready, 1 = every other cycle, 2 = random.
  initial begin
    bus.i_data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.i_data_ready = 1'b1;
        1:       bus.i_data_ready = ~bus.i_data_ready;
        default: bus.i_data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a beat is transferred at the next posedge when valid & ready at negedge.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.o_data_valid) begin
        if (prev_stall) check("stall_hold", 32'(bus.o_data), 32'(prev_data));
        if (bus.i_data_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL extra_beat: got %0h, expected no beat", bus.o_data);
          end else begin
            check("beat", 32'(bus.o_data), 32'(exp_q.pop_front()));
          end
          beats_seen++;
        end
      end
      prev_stall = bus.o_data_valid & ~bus.i_data_ready;
      prev_data  = bus.o_data;
      if (bus.o_done) done_cnt++;
    end
  end

  task automatic wait_done(input int d0);
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(posedge clk);
  endtask

  task automatic run_frame(input logic [159:0] d, input int mode, input int hold, input int gap);
    int b0;
    int d0;
    b0 = beats_seen;
    d0 = done_cnt;
    ready_mode = mode;
    @(posedge clk);
    #1;
    push_expected(d);
    bus.i_digest = d;
    bus.i_valid  = 1'b1;
    @(negedge clk);
    check("no_beat_before_edge", 32'(bus.o_data_valid), 32'd0);
    @(negedge clk);
    check("first_beat_latency", 32'(bus.o_data_valid), 32'd1);
    check("busy_in_frame", 32'(bus.o_busy), 32'd1);
    wait_done(d0);
    repeat (hold) @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (gap) @(posedge clk);
    check("frame_beats", 32'(beats_seen - b0), 32'(BEATS));
    check("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int b0;
    int d0;
    logic [159:0] dig_a;
    logic [159:0] dig_b;

    vecs[0] = '{160'h00112233445566778899aabbccddeeff01234567, 0, 3, 3};
    vecs[1] = '{160'h00112233445566778899aabbccddeeff01234567, 1, 2, 2};
    vecs[2] = '{160'hdeadbeefcafef00d0102030405060708a1b2c3d4, 0, 180, 1};
    vecs[3] = '{{160{1'b1}}, 0, 2, 2};
    vecs[4] = '{160'hab090f1e2d3c4b5a69788796a5b4c3d2e1f01234, 2, 1, 2};
    vecs[5] = '{160'hab090f1e2d3c4b5a69788796a5b4c3d2e1f01234, 1, 2, 2};

    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_digest = '0;
    #1;
    check("rst_data", 32'(bus.o_data), 32'd0);
    check("rst_data_valid", 32'(bus.o_data_valid), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].digest, vecs[v].mode, vecs[v].hold, vecs[v].gap);

    // Mid-frame re-edge with a new digest must not disturb the frame in flight.
    dig_a = 160'h0f0e0d0c0b0a09080706050403020100f1e2d3c4;
    dig_b = {20{8'h5a}};
    ready_mode = 0;
    b0 = beats_seen;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    push_expected(dig_a);
    bus.i_digest = dig_a;
    bus.i_valid  = 1'b1;
    for (int c = 0; c < 100 && beats_seen - b0 < 5; c++) @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.i_digest = dig_b;
    bus.i_valid  = 1'b1;
    wait_done(d0);
    repeat (6) @(posedge clk);
    check("midedge_beats", 32'(beats_seen - b0), 32'(BEATS));
    check("midedge_done", 32'(done_cnt - d0), 32'd1);
    check("midedge_no_new_frame", 32'(bus.o_data_valid), 32'd0);
    #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset during beat 7 abandons the frame without o_done.
    b0 = beats_seen;
    d0 = done_cnt;
    #1;
    push_expected(dig_a);
    bus.i_digest = dig_a;
    bus.i_valid  = 1'b1;
    for (int c = 0; c < 100 && beats_seen - b0 < 7; c++) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_valid", 32'(bus.o_data_valid), 32'd0);
    check("async_rst_busy", 32'(bus.o_busy), 32'd0);
    check("async_rst_done", 32'(bus.o_done), 32'd0);
    check("async_rst_data", 32'(bus.o_data), 32'd0);
    exp_q.delete();
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    check("async_rst_no_done", 32'(done_cnt - d0), 32'd0);
    #1;
    rst_n = 1'b1;
    run_frame(160'h00112233445566778899aabbccddeeff01234567, 0, 2, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hash160_digest_serializer.md
Name: hash160_digest_serializer

Overview:
- Transmit end of the Hash160 result path. The hash core presents its 160-bit digest in parallel with a level-held valid.
- This block captures the digest once per valid rising edge and streams it out byte-serially over a valid/ready interface, most-significant byte first.
- Sits between the Hash160 core output and any byte-wide sink (UART bridge, scan-out, host FIFO).

Parameters:
- DIGEST_BYTES, 20, number of digest bytes per frame; i_digest width is 8*DIGEST_BYTES.
- CNT_W, 6, beat counter width; must satisfy 2^CNT_W >= 2*DIGEST_BYTES.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  digest valid from hash core; level, may stay high indefinitely
- i_digest  input  8*DIGEST_BYTES  digest; byte 0 = i_digest[8*DIGEST_BYTES-1 -: 8]
- o_data  output  8  output byte
- o_data_valid  output  1  o_data holds a valid beat
- i_data_ready  input  1  sink accepts the beat
- o_busy  output  1  frame in progress (state SEND)
- o_done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, rst_n low): state IDLE; o_data=0, o_data_valid=0, o_busy=0, o_done=0, beat counter=0, capture register=0, valid-delay flop=0.
- Edge detect: start = i_valid & ~valid_d, where valid_d is i_valid registered every cycle.
  - If i_valid is already high at the first clock after reset release, that cycle counts as a rising edge.
- State IDLE:
  - On start, load i_digest into the shift register, clear the counter and go to SEND.
  - o_data_valid rises the next cycle, so latency is 1 cycle from the edge sample to the first beat.
- State SEND:
  - o_data_valid=1 and o_busy=1.
  - o_data = top byte of the shift register.
  - Transfer occurs at a clock edge where o_data_valid & i_data_ready.
  - On transfer: shift left by 8 and increment the counter.
  - Without transfer: o_data and the counter hold stable; no skip or duplicate.
  - On the transfer of the last beat (counter = DIGEST_BYTES-1), go to DONE; o_data_valid falls the next cycle.
- State DONE:
  - o_done=1 for exactly one cycle; o_data_valid=0, o_busy=0.
  - Next state is IDLE unconditionally.
- Rising edges of i_valid during SEND or DONE are ignored; the captured frame is not disturbed. The edge is lost, not queued.
- A held-high i_valid produces exactly one frame. A new frame requires i_valid to go low, then high.
- i_data_ready is ignored outside SEND. o_data is don't-care when o_data_valid=0 but must not change during a stalled beat.
- Back-to-back throughput: 1 beat/cycle with ready held high. Frame = DIGEST_BYTES beats + 1 DONE cycle.
- Reset mid-frame: immediate return to the reset values; the partial frame is abandoned and there is no o_done.
- No combinational path from i_data_ready to o_data_valid or o_data.

Optional Feature:
- Macro: HASH160_SER_HEX_ASCII_EN.
- Defined: each digest byte is emitted as two ASCII hex characters, high nibble first.
  - Nibble 0-9 maps to 0x30-0x39; nibble a-f maps to 0x61-0x66 (lowercase).
  - A frame is 2*DIGEST_BYTES beats; the last beat is at counter = 2*DIGEST_BYTES-1.
  - The shift register shifts by 4 per transfer.
- Undefined: raw binary bytes, DIGEST_BYTES beats per frame; no ASCII encoding logic is present.

Test Plan:
- Raw mode, binary default. i_digest = 160'h00112233445566778899aabbccddeeff01234567, single i_valid rise, ready tied 1 -> o_data sequence 00,11,22,…,ff,01,23,45,67 on 20 consecutive cycles starting 1 cycle after the edge; o_done high the cycle after beat 20; o_busy low afterwards.
- Backpressure, binary default. Same digest, i_data_ready = 1 on odd cycles only -> each byte held stable while ready=0; exactly 20 transfers, order unchanged, o_done once.
- Level-held valid, binary default. i_valid high for 200 cycles -> exactly one frame, one o_done pulse. Drop i_valid for 1 cycle, then raise with digest 160'hffff…ff -> second frame of 20 bytes of 0xff.
- Mid-frame edge, binary default. Toggle i_valid low/high during beat 5 with a different digest -> original frame completes unchanged; the new digest is not sent.
- Reset mid-frame, binary default. Assert rst_n low asynchronously during beat 7 -> o_data_valid, o_busy, o_done and o_data go to 0 without waiting for clk; no o_done; the next valid rise starts a fresh frame at byte 0.
- HASH160_SER_HEX_ASCII_EN defined. Digest starting 0xab,0x09 -> beats 0x61,0x62,0x30,0x39,…; 40 beats total, then one o_done pulse.
